// File: rtl/rotating_sprite_engine.sv
// rotating_sprite_engine: NSPRITES-channel rotating sprite line engine.
// Fetches next-line sprite rows from a shared combinational bitmap ROM during
// hblank, double-buffers them and draws them on the following line.
// Ports: clk/reset (async, active-high), hpos/vpos from hvsync_generator,
// per-channel sprite_en/x/y/rot, rom_addr/rom_bits ROM port, registered
// per-channel gfx, sticky collide and late flags, busy while fetching.
module rotating_sprite_engine #(
  parameter int NSPRITES   = 4,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int FETCH_HPOS = 256,
  parameter int ROM_AW     = 3 + $clog2(SPR_H) + $clog2(SPR_W / 8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            hpos,
  input  logic [8:0]            vpos,
  input  logic [NSPRITES-1:0]   sprite_en,
  input  logic [8*NSPRITES-1:0] sprite_x,
  input  logic [8*NSPRITES-1:0] sprite_y,
  input  logic [4*NSPRITES-1:0] sprite_rot,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [7:0]            rom_bits,
  output logic [NSPRITES-1:0]   gfx,
  output logic [NSPRITES-1:0]   collide,
  output logic                  late,
  output logic                  busy
);

  localparam int BYTES = SPR_W / 8;
  localparam int RW    = $clog2(SPR_H);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IW    = (NSPRITES > 1) ? $clog2(NSPRITES) : 1;
  localparam int CW    = $clog2(SPR_W);

  typedef enum logic [1:0] {IDLE, CHECK, SETUP, FETCH} state_t;

  state_t                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [BW-1:0]                     b_q, b_d;
  logic [RW-1:0]                     row_q, row_d;
  logic [2:0]                        bitmap_q, bitmap_d;
  logic                              hmir_q, hmir_d;
  logic [ROM_AW-1:0]                 rom_addr_q, rom_addr_d;
  logic [NSPRITES-1:0][SPR_W-1:0]    pending_q, pending_d;
  logic [NSPRITES-1:0]               pending_valid_q, pending_valid_d;
  logic [NSPRITES-1:0][7:0]          pending_x_q, pending_x_d;
  logic [NSPRITES-1:0]               pending_hm_q, pending_hm_d;
  logic [NSPRITES-1:0][SPR_W-1:0]    active_q, active_d;
  logic [NSPRITES-1:0][7:0]          active_x_q, active_x_d;
  logic [NSPRITES-1:0]               active_hm_q, active_hm_d;
  logic [NSPRITES-1:0]               armed_q, armed_d;
  logic [NSPRITES-1:0]               drawing_q, drawing_d;
  logic [NSPRITES-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [NSPRITES-1:0]               gfx_q, gfx_d;
  logic [NSPRITES-1:0]               collide_q, collide_d;
  logic                              late_q, late_d;

  logic [NSPRITES-1:0][7:0]          x_arr, y_arr;
  logic [NSPRITES-1:0][3:0]          rot_arr;
  logic                              line_start, frame_clr, late_set, adv;
  logic [8:0]                        vnext, diff;
  logic [3:0]                        cur_rot;
  logic [2:0]                        chk_bm;
  logic                              chk_vm, chk_hm, hit;

  assign line_start = (hpos == 9'd0);
  assign frame_clr  = line_start && (vpos == 9'd0);

  assign rom_addr = rom_addr_q;
  assign gfx      = gfx_q;
  assign collide  = collide_q;
  assign late     = late_q;
  assign busy     = (state_q != IDLE);

  function automatic logic pix(input logic [SPR_W-1:0] r, input logic hm,
                               input logic [CW-1:0] k);
    pix = hm ? r[CW'(SPR_W - 1) - k] : r[k];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NSPRITES; i++) begin
      x_arr[i]   = sprite_x[8*i +: 8];
      y_arr[i]   = sprite_y[8*i +: 8];
      rot_arr[i] = sprite_rot[4*i +: 4];
    end
  end

  // Rotation: four base bitmaps per quadrant, odd quadrants walk the bitmaps
  // backwards and the quadrant picks the mirror combination.
  always_comb begin
    cur_rot = rot_arr[idx_q];
    vnext   = vpos + 9'd1;
    diff    = vnext - {1'b0, y_arr[idx_q]};
    hit     = sprite_en[idx_q] && (diff < 9'(SPR_H));
    chk_bm  = {1'b0, cur_rot[1:0]};
    chk_vm  = 1'b0;
    chk_hm  = 1'b0;
    case (cur_rot[3:2])
      2'd0: begin chk_bm = {1'b0, cur_rot[1:0]}; end
      2'd1: begin chk_bm = 3'd0 - cur_rot[2:0]; chk_vm = 1'b1; end
      2'd2: begin chk_bm = {1'b0, cur_rot[1:0]}; chk_vm = 1'b1; chk_hm = 1'b1; end
      default: begin chk_bm = 3'd0 - cur_rot[2:0]; chk_hm = 1'b1; end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    b_d             = b_q;
    row_d           = row_q;
    bitmap_d        = bitmap_q;
    hmir_d          = hmir_q;
    rom_addr_d      = rom_addr_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    pending_x_d     = pending_x_q;
    pending_hm_d    = pending_hm_q;
    late_set        = 1'b0;
    adv             = 1'b0;
    case (state_q)
      IDLE: begin
        if (hpos == 9'(FETCH_HPOS)) begin
          pending_valid_d = '0;
          idx_d           = '0;
          state_d         = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          row_d    = chk_vm ? ~diff[RW-1:0] : diff[RW-1:0];
          bitmap_d = chk_bm;
          hmir_d   = chk_hm;
          b_d      = '0;
          state_d  = SETUP;
        end else begin
          adv = 1'b1;
        end
      end
      SETUP: begin
        rom_addr_d = {bitmap_q, row_q, b_q};
        state_d    = FETCH;
      end
      default: begin
        pending_d[idx_q][8*b_q +: 8] = rom_bits;
        if (b_q == BW'(BYTES - 1)) begin
          pending_valid_d[idx_q] = 1'b1;
          pending_x_d[idx_q]     = x_arr[idx_q];
          pending_hm_d[idx_q]    = hmir_q;
          adv                    = 1'b1;
        end else begin
          b_d     = b_q + 1'b1;
          state_d = SETUP;
        end
      end
    endcase
    if (adv) begin
      if (idx_q == IW'(NSPRITES - 1)) begin
        state_d = IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = CHECK;
      end
    end
    // Line start aborts any fetch; the channel being fetched keeps its cleared
    // valid bit so a partial row is never armed.
    if (line_start) begin
      late_set        = (state_q != IDLE);
      state_d         = IDLE;
      pending_valid_d = pending_valid_q;
    end
  end

  // A sprite at x = 0 has to start in the transfer cycle itself, so it is
  // drawn straight from the pending buffer.
  always_comb begin
    active_d    = active_q;
    active_x_d  = active_x_q;
    active_hm_d = active_hm_q;
    armed_d     = armed_q;
    drawing_d   = drawing_q;
    cnt_d       = cnt_q;
    gfx_d       = '0;
    for (int unsigned i = 0; i < NSPRITES; i++) begin
      if (line_start) begin
        active_d[i]    = pending_q[i];
        active_x_d[i]  = pending_x_q[i];
        active_hm_d[i] = pending_hm_q[i];
        armed_d[i]     = pending_valid_q[i];
        drawing_d[i]   = 1'b0;
        cnt_d[i]       = '0;
        if (pending_valid_q[i] && (pending_x_q[i] == 8'd0)) begin
          gfx_d[i]     = pix(pending_q[i], pending_hm_q[i], '0);
          armed_d[i]   = 1'b0;
          drawing_d[i] = 1'b1;
          cnt_d[i]     = CW'(1);
        end
      end else if (drawing_q[i]) begin
        gfx_d[i] = pix(active_q[i], active_hm_q[i], cnt_q[i]);
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (cnt_q[i] == CW'(SPR_W - 1)) begin
          drawing_d[i] = 1'b0;
        end
      end else if (armed_q[i] && (hpos == {1'b0, active_x_q[i]})) begin
        gfx_d[i]     = pix(active_q[i], active_hm_q[i], '0);
        armed_d[i]   = 1'b0;
        drawing_d[i] = 1'b1;
        cnt_d[i]     = CW'(1);
      end
    end
  end

  always_comb begin
    collide_d = frame_clr ? '0 : collide_q;
    for (int unsigned i = 0; i < NSPRITES; i++) begin
      if (gfx_q[i] && |(gfx_q & ~(NSPRITES'(1) << i))) begin
        collide_d[i] = 1'b1;
      end
    end
    late_d = (frame_clr ? 1'b0 : late_q) | late_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      b_q             <= '0;
      row_q           <= '0;
      bitmap_q        <= '0;
      hmir_q          <= 1'b0;
      rom_addr_q      <= '0;
      pending_q       <= '0;
      pending_valid_q <= '0;
      pending_x_q     <= '0;
      pending_hm_q    <= '0;
      active_q        <= '0;
      active_x_q      <= '0;
      active_hm_q     <= '0;
      armed_q         <= '0;
      drawing_q       <= '0;
      cnt_q           <= '0;
      gfx_q           <= '0;
      collide_q       <= '0;
      late_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      b_q             <= b_d;
      row_q           <= row_d;
      bitmap_q        <= bitmap_d;
      hmir_q          <= hmir_d;
      rom_addr_q      <= rom_addr_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      pending_x_q     <= pending_x_d;
      pending_hm_q    <= pending_hm_d;
      active_q        <= active_d;
      active_x_q      <= active_x_d;
      active_hm_q     <= active_hm_d;
      armed_q         <= armed_d;
      drawing_q       <= drawing_d;
      cnt_q           <= cnt_d;
      gfx_q           <= gfx_d;
      collide_q       <= collide_d;
      late_q          <= late_d;
    end
  end

endmodule

// File: tb/tb_rotating_sprite_engine.sv
module tb_rotating_sprite_engine;

  localparam int NS    = 4;
  localparam int SW    = 16;
  localparam int SH    = 16;
  localparam int BYTES = SW / 8;
  localparam int AW    = 3 + $clog2(SH) + $clog2(BYTES);
  localparam int HTOT  = 320;

  logic            clk = 1'b0;
  logic            reset;
  logic [8:0]      hpos, vpos;
  logic [NS-1:0]   sprite_en;
  logic [8*NS-1:0] sprite_x, sprite_y;
  logic [4*NS-1:0] sprite_rot;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_bits;
  logic [NS-1:0]   gfx, collide;
  logic            late, busy;

  logic [7:0] rom_mem [0:(1<<AW)-1];
  assign rom_bits = rom_mem[rom_addr];

  rotating_sprite_engine #(
    .NSPRITES  (NS),
    .SPR_W     (SW),
    .SPR_H     (SH),
    .FETCH_HPOS(256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .sprite_en (sprite_en),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .sprite_rot(sprite_rot),
    .rom_addr  (rom_addr),
    .rom_bits  (rom_bits),
    .gfx       (gfx),
    .collide   (collide),
    .late      (late),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-line capture: index h holds the outputs registered from hpos == h,
  // i.e. what is on the pins while hpos == h+1.
  logic [HTOT-1:0] got_gfx [NS];
  logic [AW-1:0]   rec_addr [HTOT];
  logic [NS-1:0]   rec_coll [HTOT];
  logic            rec_late [HTOT];
  logic            rec_busy [HTOT];

  task automatic run_line(input int v, input int hend);
    for (int i = 0; i < NS; i++) got_gfx[i] = '0;
    for (int h = 0; h < hend; h++) begin
      hpos = 9'(h);
      vpos = 9'(v);
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) got_gfx[i][h] = gfx[i];
      rec_addr[h] = rom_addr;
      rec_coll[h] = collide;
      rec_late[h] = late;
      rec_busy[h] = busy;
    end
  endtask

  task automatic set_ch(input int ch, input logic en, input int x, input int y, input int rot);
    sprite_en[ch]          = en;
    sprite_x[8*ch +: 8]    = 8'(x);
    sprite_y[8*ch +: 8]    = 8'(y);
    sprite_rot[4*ch +: 4]  = 4'(rot);
  endtask

  // Reference: which samples of line L carry a set pixel for one sprite.
  function automatic logic [HTOT-1:0] model_line(input int L, input logic en,
                                                 input int x, input int y, input int rot);
    logic [HTOT-1:0] e;
    logic [SW-1:0]   bits;
    int r, q, bm, fr, m;
    logic vm, hm;
    e = '0;
    r = (((L - y) % 512) + 512) % 512;
    if (!en || r >= SH) return e;
    q = rot / 4;
    m = (8 - (rot % 8)) % 8;
    case (q)
      0: begin bm = rot % 4; vm = 0; hm = 0; end
      1: begin bm = m;       vm = 1; hm = 0; end
      2: begin bm = rot % 4; vm = 1; hm = 1; end
      default: begin bm = m; vm = 0; hm = 1; end
    endcase
    fr = vm ? (SH - 1 - r) : r;
    for (int b = 0; b < BYTES; b++) bits[8*b +: 8] = rom_mem[(bm * SH + fr) * BYTES + b];
    for (int k = 0; k < SW; k++)
      if (x + k < HTOT) e[x + k] = hm ? bits[SW - 1 - k] : bits[k];
    return e;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = 8'h00;
  endtask

  task automatic test_reset();
    logic [HTOT-1:0] e;
    clear_rom();
    rom_mem[4] = 8'hFF; rom_mem[5] = 8'hFF;
    set_ch(0, 1'b1, 40, 98, 0);
    for (int c = 1; c < NS; c++) set_ch(c, 1'b0, 0, 0, 0);
    run_line(99, 259);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_midfetch: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({gfx, collide, late, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gfx=%b collide=%b late=%b busy=%b expected all 0",
               gfx, collide, late, busy);
    end
    tests_run++;
    if (rom_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset_rom_addr: got %h expected 00", rom_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_line(100, HTOT);
    e = '0;
    for (int c = 0; c < NS; c++) begin
      tests_run++;
      if (got_gfx[c] !== e) begin
        tests_failed++;
        $display("FAIL reset_no_draw ch%0d: got %h expected %h", c, got_gfx[c], e);
      end
    end
  endtask

  task automatic test_rot(input string name, input int rot, input logic [AW-1:0] a0,
                          input logic [7:0] b0, input logic [7:0] b1, input int pix_h);
    logic [HTOT-1:0] e;
    clear_rom();
    rom_mem[a0] = b0; rom_mem[a0 + 1] = b1;
    set_ch(0, 1'b1, 40, 100, rot);
    for (int c = 1; c < NS; c++) set_ch(c, 1'b0, 0, 0, 0);
    run_line(99, HTOT);
    tests_run++;
    if (rec_addr[258] !== a0) begin
      tests_failed++;
      $display("FAIL %s addr_byte0: got %h expected %h", name, rec_addr[258], a0);
    end
    tests_run++;
    if (rec_addr[260] !== AW'(a0 + 1)) begin
      tests_failed++;
      $display("FAIL %s addr_byte1: got %h expected %h", name, rec_addr[260], AW'(a0 + 1));
    end
    run_line(100, HTOT);
    for (int c = 0; c < NS; c++) begin
      e = '0;
      if (c == 0) e[pix_h] = 1'b1;
      tests_run++;
      if (got_gfx[c] !== e) begin
        tests_failed++;
        $display("FAIL %s gfx ch%0d: got %h expected %h", name, c, got_gfx[c], e);
      end
    end
  endtask

  task automatic test_collide();
    logic [HTOT-1:0] e;
    clear_rom();
    rom_mem[0] = 8'hFF; rom_mem[1] = 8'hFF;
    set_ch(0, 1'b1, 60, 100, 0);
    set_ch(1, 1'b1, 60, 100, 0);
    set_ch(2, 1'b1, 150, 100, 0);
    set_ch(3, 1'b0, 0, 0, 0);
    run_line(0, HTOT);
    run_line(99, HTOT);
    tests_run++;
    if (rec_coll[HTOT-1] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL collide_before: got %b expected 0000", rec_coll[HTOT-1]);
    end
    run_line(100, HTOT);
    tests_run++;
    if (rec_coll[HTOT-1] !== 4'b0011) begin
      tests_failed++;
      $display("FAIL collide_set: got %b expected 0011", rec_coll[HTOT-1]);
    end
    e = '0;
    for (int k = 150; k < 166; k++) e[k] = 1'b1;
    tests_run++;
    if (got_gfx[2] !== e) begin
      tests_failed++;
      $display("FAIL collide_ch2_gfx: got %h expected %h", got_gfx[2], e);
    end
    for (int c = 0; c < NS; c++) set_ch(c, 1'b0, 0, 0, 0);
    run_line(240, HTOT);
    run_line(300, HTOT);
    tests_run++;
    if (rec_coll[HTOT-1] !== 4'b0011) begin
      tests_failed++;
      $display("FAIL collide_held_vblank: got %b expected 0011", rec_coll[HTOT-1]);
    end
    run_line(0, HTOT);
    tests_run++;
    if (rec_coll[0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL collide_frame_clear: got %b expected 0000", rec_coll[0]);
    end
  endtask

  task automatic test_late();
    logic [HTOT-1:0] e;
    clear_rom();
    rom_mem[0] = 8'h80; rom_mem[1] = 8'h00;
    set_ch(0, 1'b1, 40, 100, 0);
    set_ch(1, 1'b1, 100, 100, 0);
    set_ch(2, 1'b0, 0, 0, 0);
    set_ch(3, 1'b0, 0, 0, 0);
    run_line(99, 264);
    tests_run++;
    if (rec_late[263] !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_before_wrap: got %b expected 0", rec_late[263]);
    end
    run_line(100, HTOT);
    tests_run++;
    if (rec_late[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL late_set: got %b expected 1", rec_late[0]);
    end
    tests_run++;
    if (rec_busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_busy_cleared: got %b expected 0", rec_busy[0]);
    end
    for (int c = 0; c < NS; c++) begin
      e = '0;
      if (c == 0) e[47] = 1'b1;
      tests_run++;
      if (got_gfx[c] !== e) begin
        tests_failed++;
        $display("FAIL late_gfx ch%0d: got %h expected %h", c, got_gfx[c], e);
      end
    end
  endtask

  task automatic test_random_lines();
    int              vs[$];
    logic [HTOT-1:0] pred [NS];
    logic [HTOT-1:0] nxt  [NS];
    logic [NS-1:0]   coll_exp;
    logic            framed, others;
    int              v, en, x, y, rot;
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = 8'($urandom);
    for (int l = 507; l < 512; l++) vs.push_back(l);
    for (int l = 0; l <= 40; l++) vs.push_back(l);
    framed   = 1'b0;
    coll_exp = '0;
    for (int c = 0; c < NS; c++) pred[c] = '0;
    foreach (vs[n]) begin
      v = vs[n];
      for (int c = 0; c < NS; c++) begin
        en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        x   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
        y   = (v >= 500) ? int'($urandom_range(0, 3))
                         : (((v + 1) - int'($urandom_range(0, SH + 4))) & 255);
        rot = int'($urandom_range(0, 15));
        set_ch(c, en[0], x, y, rot);
        nxt[c] = model_line((v + 1) % 512, en[0], x, y, rot);
      end
      run_line(v, HTOT);
      if (n > 0) begin
        for (int c = 0; c < NS; c++) begin
          tests_run++;
          if (got_gfx[c] !== pred[c]) begin
            tests_failed++;
            $display("FAIL rand_gfx line%0d ch%0d: got %h expected %h", v, c, got_gfx[c], pred[c]);
          end
        end
        if (v == 0) begin
          framed   = 1'b1;
          coll_exp = '0;
        end
        for (int h = 0; h < HTOT; h++)
          for (int i = 0; i < NS; i++) begin
            others = 1'b0;
            for (int j = 0; j < NS; j++) if (j != i && pred[j][h]) others = 1'b1;
            if (pred[i][h] && others) coll_exp[i] = 1'b1;
          end
        if (framed) begin
          tests_run++;
          if (rec_coll[HTOT-1] !== coll_exp) begin
            tests_failed++;
            $display("FAIL rand_collide line%0d: got %b expected %b", v, rec_coll[HTOT-1], coll_exp);
          end
        end
      end
      for (int c = 0; c < NS; c++) pred[c] = nxt[c];
    end
    tests_run++;
    if (rec_late[HTOT-1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_late: got %b expected 0", rec_late[HTOT-1]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    hpos       = '0;
    vpos       = '0;
    sprite_en  = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    sprite_rot = '0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_rot("rot0",  0,  AW'(8'h00), 8'h80, 8'h00, 47);
    test_rot("rot5",  5,  AW'(8'h7E), 8'h01, 8'h00, 40);
    test_rot("rot12", 12, AW'(8'h80), 8'h01, 8'h00, 55);
    test_collide();
    test_late();
    test_random_lines();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
